// File: rtl/px_pulse2req_pkg.sv
// rtl/px_pulse2req_pkg.sv - shared types and constants for the pulse CDC source stage
package px_pulse2req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } px_state_e;

  localparam int PX_SYNC_DEPTH = 2;

endpackage

// File: rtl/px_bit_sync_r.sv
// rtl/px_bit_sync_r.sv - multi-flop bit synchroniser with synchronous active-high reset
module px_bit_sync_r
  import px_pulse2req_pkg::*;
#(
  parameter int STAGES = PX_SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/px_pulse2req.sv
// rtl/px_pulse2req.sv - queues event pulses and sends each as a four-phase req/ack transfer
module px_pulse2req
  import px_pulse2req_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_level,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             drop
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  px_state_e        state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             drop_q, drop_d;
  logic             ack_sync;
  logic             launch;

  px_bit_sync_r #(
    .STAGES(PX_SYNC_DEPTH)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_level),
    .q   (ack_sync)
  );

  // A high ack_sync in IDLE is a stale acknowledge and blocks launch.
  assign launch = (state_q == ST_IDLE) && !ack_sync &&
                  ((pending_q != '0) || pulse_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (launch)    state_d = ST_REQ;
      ST_REQ:     if (ack_sync)  state_d = ST_RELEASE;
      ST_RELEASE: if (!ack_sync) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level   = (state_q == ST_REQ);
    busy    = (state_q != ST_IDLE) || (pending_q != '0) || ack_sync;
    pending = pending_q;
    drop    = drop_q;
  end

  // A pulse arriving with a launch replaces the launched queue entry.
  always_comb begin
    pending_d = pending_q;
    drop_d    = 1'b0;
    if (launch) begin
      if ((pending_q != '0) && !pulse_in) begin
        pending_d = pending_q - 1'b1;
      end
    end else if (pulse_in) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

endmodule
